// File: rtl/dmem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// The MEMSIZE_* codes match what the controller's setMemSize produces.
package dmem_responder_pkg;

  localparam logic [1:0] MEMSIZE_B   = 2'b00;
  localparam logic [1:0] MEMSIZE_H   = 2'b01;
  localparam logic [1:0] MEMSIZE_W   = 2'b10;
  localparam logic [1:0] MEMSIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte-lane write enables for a store of the given size at byte offset a.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      MEMSIZE_B: be = 4'b0001 << a;
      MEMSIZE_H: be = 4'b0011 << {a[1], 1'b0};
      MEMSIZE_W: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data into every lane it could occupy.
  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    r = wd;
    case (size)
      MEMSIZE_B: r = {4{wd[7:0]}};
      MEMSIZE_H: r = {2{wd[15:0]}};
      default:   r = wd;
    endcase
    return r;
  endfunction

  // Move the addressed lane down to bit 0 and zero everything above it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {a, 3'b000};
    r  = 32'h0;
    case (size)
      MEMSIZE_B: r = {24'h0, sh[7:0]};
      MEMSIZE_H: r = {16'h0, sh[15:0]};
      MEMSIZE_W: r = word;
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

  // Misaligned half/word or the reserved size code.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] a);
    return ((size == MEMSIZE_H) && a[0]) ||
           ((size == MEMSIZE_W) && (a != 2'b00)) ||
           (size == MEMSIZE_RSV);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the CPU (master) and the data memory (slave).
interface dmem_responder_if;
  logic        i_memReq;
  logic        i_memWrite;
  logic [1:0]  i_memSize;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_valid;
  logic        o_err;
  logic        o_stall;

  modport master (
    output i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
    input  o_rdata, o_valid, o_err, o_stall
  );

  modport slave (
    input  i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
    output o_rdata, o_valid, o_err, o_stall
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
// Contents are never cleared by reset.
module dmem_byte_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Byte-lane writes and the read-register update share one enabled access.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for the MEM stage.
//
//   state | meaning
//   IDLE  | no access in flight; a request is latched when i_memReq is seen
//   WAIT  | access accepted, counting down the extra wait states
//   RESP  | one-cycle completion: o_valid high, load data / error presented
//
// The RAM is touched only on the edge that enters RESP. With zero wait states
// that edge is the acceptance edge, so the access fields come straight from the
// bus in IDLE and from the latched copy afterwards.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic                  valid_q;

  logic [ADDR_WIDTH+1:0] acc_addr_d;
  logic [1:0]            acc_size_d;
  logic                  acc_write_d;
  logic [31:0]           acc_wdata_d;
  logic                  acc_err_d;
  logic                  go_resp;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;

  // Address bits above the array wrap and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.i_addr[31:ADDR_WIDTH+2];

  // Select the access fields and decide whether this edge enters RESP.
  always_comb begin
    acc_addr_d  = addr_q;
    acc_size_d  = size_q;
    acc_write_d = write_q;
    acc_wdata_d = wdata_q;
    if (state_q == IDLE) begin
      acc_addr_d  = bus.i_addr[ADDR_WIDTH+1:0];
      acc_size_d  = bus.i_memSize;
      acc_write_d = bus.i_memWrite;
      acc_wdata_d = bus.i_wdata;
    end
    acc_err_d = access_err(acc_size_d, acc_addr_d[1:0]);
    go_resp   = ((state_q == IDLE) && bus.i_memReq && (WAIT_CYCLES == 0)) ||
                ((state_q == WAIT) && (cnt_q == 4'd0));
    // A reset on the would-be RESP edge must not let a pending store land.
    ram_en    = go_resp && !acc_err_d && !reset;
    ram_we    = acc_write_d ? byte_en(acc_size_d, acc_addr_d[1:0]) : 4'b0000;
  end

  // Request FSM with latched access fields and registered completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= MEMSIZE_B;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.i_memReq) begin
            addr_q  <= acc_addr_d;
            size_q  <= acc_size_d;
            write_q <= acc_write_d;
            wdata_q <= acc_wdata_d;
            err_q   <= acc_err_d;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  dmem_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (acc_addr_d[ADDR_WIDTH+1:2]),
    .wdata_i (wdata_rep(acc_size_d, acc_wdata_d)),
    .rdata_o (ram_rdata)
  );

  assign bus.o_valid = valid_q;
  assign bus.o_err   = valid_q && err_q;
  // Stores and errored accesses return zero; load data only alongside o_valid.
  assign bus.o_rdata = (valid_q && !err_q && !write_q) ?
                       lane_extract(ram_rdata, size_q, addr_q[1:0]) : 32'h0;
  assign bus.o_stall = bus.i_memReq && (state_q != RESP);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipeline's MEM stage.
- Accepts the memory request from the controller: memReq, memWrite, memSize, plus address and write data from the datapath.
- Models a wait-stated, byte-addressable word RAM and returns right-justified, zero-extended load data with a completion pulse.
- Asserts a stall toward the hazard unit while a request is outstanding. Sign extension (isLoadSigned) remains CPU-side.

Parameters:
- ADDR_WIDTH, 12, word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, extra wait states between acceptance and response (legal range 0..15).

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- i_memReq  input  1  request valid; held high with all fields stable until o_valid.
- i_memWrite  input  1  1 = store, 0 = load.
- i_memSize  input  2  00 byte, 01 half, 10 word, 11 reserved.
- i_addr  input  32  byte address; only bits [ADDR_WIDTH+1:0] are used, upper bits are ignored (wrap).
- i_wdata  input  32  store data, right-justified.
- o_rdata  output  32  load data, right-justified, zero-extended; valid only with o_valid.
- o_valid  output  1  one-cycle completion pulse.
- o_err  output  1  misaligned or reserved-size flag, qualified by o_valid.
- o_stall  output  1  combinational: i_memReq & (state != RESP).

Behaviour:
- Reset: state IDLE, wait counter 0, o_rdata 0, o_valid 0, o_err 0. RAM contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
  - IDLE & i_memReq: latch addr/size/write/wdata. Go to WAIT with counter = WAIT_CYCLES-1, or go straight to RESP if WAIT_CYCLES = 0.
  - WAIT: decrement the counter; at 0, go to RESP.
  - RESP: o_valid = 1 for exactly one cycle, then IDLE.
- Latency: if i_memReq first goes high in cycle 0, o_stall is high in cycles 0..WAIT_CYCLES and o_valid is high in cycle WAIT_CYCLES+1, with o_stall low in that cycle.
  - Minimum access time is 2 cycles.
  - A new request may be sampled in the cycle after RESP, so back-to-back accesses take WAIT_CYCLES+2 cycles each.
- Error check: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - o_err = 1 in RESP, o_rdata = 0, no RAM write.
- Store: performed on the edge entering RESP, using byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],0}
  - word: 1111
  - Write data is replicated into the active lanes.
- Load: the word is read on the edge entering RESP. The selected lane is shifted to bit 0 and upper bits are zeroed.
  - A load issued immediately after a store to the same word returns the new data.
- Fields are used only from the latched copy; changes on the inputs after acceptance are ignored.
- Flush/abandon: if i_memReq drops after acceptance, the access still completes and the RESP pulse still occurs. Dropping the request is a protocol violation that the CPU must not commit.
- Reset in WAIT or RESP: return to IDLE with no pulse. A store that has not yet reached the RESP edge is not performed.
- i_memReq low in IDLE: no state change and o_stall = 0.

Decomposition:
- Shared package:
  - MEMSIZE_B/H/W/RSV encodings, shared with setMemSize.
  - FSM state encodings IDLE/WAIT/RESP.
  - Byte-enable and lane-extract helper functions.
- One sub-module, dmem_byte_ram:
  - 2^ADDR_WIDTH x 32 synchronous array with 4 byte write enables and a registered read port.
  - The responder FSM drives its enable on the RESP transition.

Test Plan:
- WAIT_CYCLES=1; store word 0xDEADBEEF @0x100; then load byte @0x101 -> o_stall high 2 cycles, o_valid in cycle 2, o_rdata=0x000000BE, o_err=0.
- Store half 0xA5A5 @0x102; load word @0x100 -> o_rdata=0xA5A5BEEF; load half @0x102 -> 0x0000A5A5 (zero-extended).
- Load word @0x103 and store half @0x101 (wdata 0xFFFF) -> o_err=1 with o_valid, o_rdata=0; a follow-up word load @0x100 still returns 0xA5A5BEEF.
- WAIT_CYCLES=2, request held 4 cycles -> o_stall high in cycles 0,1,2; o_valid only in cycle 3. With WAIT_CYCLES=0, o_valid in cycle 1.
- Store word 0x12345678 @0x200 with reset pulsed in the WAIT cycle -> no o_valid, all outputs 0 next cycle; a later load @0x200 returns the prior content (0x00000000 if never written).
- Four back-to-back byte stores 0x11,0x22,0x33,0x44 to 0x300..0x303, then word load @0x300 -> 0x44332211; each access takes exactly WAIT_CYCLES+2 cycles.
